// File: rtl/neuro_matvec_engine.sv
// N x N signed matrix-vector engine: streams in W then x, one shared MAC, requantised bytes out.
// Optional NEURO_RELU_EN clamps each requantised result to >= 0.
module neuro_matvec_engine #(
  parameter int N      = 3,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int SHIFT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              keep_w,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    LOAD_W  = 3'd0,
    LOAD_X  = 3'd1,
    COMPUTE = 3'd2,
    SEND    = 3'd3
  } state_e;

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  state_e                   state_q, state_d;
  logic [CW-1:0]            row_q, row_d, col_q, col_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     done_q, done_d;

  logic [DATA_W-1:0]        w_q [N][N];
  logic [DATA_W-1:0]        x_q [N];
  logic [DATA_W-1:0]        y_q [N];

  logic signed [ACC_W-1:0]  w_ext, x_ext, prod, sum;
  logic [DATA_W-1:0]        y_new;
  logic                     in_fire, out_fire;

  function automatic logic [DATA_W-1:0] requant(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] t;
    logic [DATA_W-1:0]       r;
    t = a >>> SHIFT;
    if (t > SAT_MAX)      r = SAT_MAX[DATA_W-1:0];
    else if (t < SAT_MIN) r = SAT_MIN[DATA_W-1:0];
    else                  r = t[DATA_W-1:0];
`ifdef NEURO_RELU_EN
    if (r[DATA_W-1]) r = '0;
`endif
    return r;
  endfunction

  // Operands sign-extended to the accumulator width so the product keeps full precision.
  always_comb begin
    w_ext = {{(ACC_W-DATA_W){w_q[row_q][col_q][DATA_W-1]}}, w_q[row_q][col_q]};
    x_ext = {{(ACC_W-DATA_W){x_q[col_q][DATA_W-1]}}, x_q[col_q]};
    prod  = w_ext * x_ext;
    sum   = acc_q + prod;
    y_new = requant(sum);
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    acc_d     = acc_q;
    done_d    = 1'b0;
    in_ready  = (state_q == LOAD_W) || (state_q == LOAD_X);
    out_valid = (state_q == SEND);
    busy      = (state_q == COMPUTE) || (state_q == SEND);
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    case (state_q)
      LOAD_W: if (in_fire) begin
        if (col_q == LAST) begin
          col_d = '0;
          if (row_q == LAST) begin
            row_d   = '0;
            state_d = LOAD_X;
          end else begin
            row_d = row_q + CW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      LOAD_X: if (in_fire) begin
        if (col_q == LAST) begin
          col_d   = '0;
          row_d   = '0;
          acc_d   = '0;
          state_d = COMPUTE;
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      COMPUTE: begin
        if (col_q == LAST) begin
          acc_d = '0;
          col_d = '0;
          if (row_q == LAST) begin
            row_d   = '0;
            state_d = SEND;
          end else begin
            row_d = row_q + CW'(1);
          end
        end else begin
          acc_d = sum;
          col_d = col_q + CW'(1);
        end
      end
      SEND: if (out_fire) begin
        if (row_q == LAST) begin
          row_d   = '0;
          done_d  = 1'b1;
          state_d = keep_w ? LOAD_X : LOAD_W;
        end else begin
          row_d = row_q + CW'(1);
        end
      end
      default: state_d = LOAD_W;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_W;
      row_q   <= '0;
      col_q   <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
    end
  end

  // Operand and result storage survives reset so weights can be reused across frames.
  always_ff @(posedge clk) begin
    if (in_fire && state_q == LOAD_W) w_q[row_q][col_q] <= in_data;
    if (in_fire && state_q == LOAD_X) x_q[col_q] <= in_data;
    if (state_q == COMPUTE && col_q == LAST) y_q[row_q] <= y_new;
  end

  assign out_data = out_valid ? y_q[row_q] : '0;
  assign done     = done_q;
  assign state    = state_q;

endmodule

// File: tb/tb_neuro_matvec_engine.sv
// Scoreboard bench for neuro_matvec_engine (N=3, DATA_W=8, ACC_W=20, SHIFT=4).
module tb_neuro_matvec_engine;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int AW = 20;
  localparam int SH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          keep_w;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic [2:0]    state;

  neuro_matvec_engine #(.N(N), .DATA_W(DW), .ACC_W(AW), .SHIFT(SH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .keep_w(keep_w),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [DW-1:0] sb[$];
  int tb_w [N][N];
  int tb_x [N];
  int last_hs;
  logic mon_en = 1'b0;
  logic seen_zero = 1'b0;

  always @(negedge clk) if (mon_en && state == 3'd0) seen_zero = 1'b1;

  function automatic logic [DW-1:0] model_y(input int r);
    int acc;
    int t;
    acc = 0;
    for (int c = 0; c < N; c++) acc += tb_w[r][c] * tb_x[c];
    t = acc >>> SH;
    if (t > 127)  t = 127;
    if (t < -128) t = -128;
`ifdef NEURO_RELU_EN
    if (t < 0) t = 0;
`endif
    return 8'(t);
  endfunction

  task automatic drive_byte(input int b, input string tag);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = 8'(b);
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL %s accept: in_ready=%b required 1", tag, in_ready);
    else pass_cnt++;
    last_hs = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_w();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) drive_byte(tb_w[r][c], "w_byte");
  endtask

  task automatic send_x();
    for (int i = 0; i < N; i++) drive_byte(tb_x[i], "x_byte");
    for (int r = 0; r < N; r++) sb.push_back(model_y(r));
  endtask

  task automatic recv_frame(input string tag, output int first_cyc);
    int got;
    int guard;
    logic [DW-1:0] exp;
    got = 0;
    guard = 0;
    first_cyc = -1;
    out_ready = 1'b1;
    while (got < N && guard < 500) begin
      if (out_valid === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (sb.size() > 0) exp = sb.pop_front();
        else exp = 'x;
        total_cnt++;
        if (out_data !== exp) $display("FAIL %s y[%0d]: got %h required %h", tag, got, out_data, exp);
        else pass_cnt++;
        got++;
      end
      @(negedge clk);
      guard++;
    end
    total_cnt++;
    if (got != N) $display("FAIL %s byte_count: got %0d required %0d", tag, got, N);
    else pass_cnt++;
    total_cnt++;
    if (done !== 1'b1) $display("FAIL %s done_pulse: done=%b required 1", tag, done);
    else pass_cnt++;
    @(negedge clk);
    out_ready = 1'b0;
    total_cnt++;
    if (done !== 1'b0) $display("FAIL %s done_width: done=%b required 0", tag, done);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; keep_w = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++; if (state !== 3'd0) $display("FAIL reset_state: got %0d required 0", state); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 8'h00) $display("FAIL reset_out_data: got %h required 00", out_data); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b required 0", done); else pass_cnt++;
  endtask

  task automatic test_identity();
    int first;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) tb_w[r][c] = (r == c) ? 16 : 0;
    tb_x[0] = 16; tb_x[1] = 32; tb_x[2] = -48;
    keep_w = 1'b0;
    send_w();
    send_x();
    total_cnt++; if (state !== 3'd2) $display("FAIL ident_compute_state: got %0d required 2", state); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL ident_busy: got %b required 1", busy); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL ident_in_ready: got %b required 0", in_ready); else pass_cnt++;
    recv_frame("identity", first);
    total_cnt++;
    if (first - last_hs != N*N + 1) $display("FAIL ident_latency: got %0d required %0d", first - last_hs, N*N + 1);
    else pass_cnt++;
    total_cnt++; if (state !== 3'd0) $display("FAIL ident_end_state: got %0d required 0", state); else pass_cnt++;
  endtask

  task automatic test_saturation();
    int first;
    keep_w = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) tb_w[r][c] = 127;
    for (int i = 0; i < N; i++) tb_x[i] = 127;
    send_w(); send_x();
    recv_frame("sat_pos", first);
    for (int i = 0; i < N; i++) tb_x[i] = -128;
    send_w(); send_x();
    recv_frame("sat_neg", first);
  endtask

  task automatic test_backpressure();
    int first;
    int guard;
    logic [DW-1:0] exp0;
    keep_w = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) tb_w[r][c] = int'($urandom_range(0, 255)) - 128;
    for (int i = 0; i < N; i++) tb_x[i] = int'($urandom_range(0, 255)) - 128;
    send_w(); send_x();
    out_ready = 1'b0;
    guard = 0;
    while (out_valid !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_reach_send: out_valid=%b required 1", out_valid); else pass_cnt++;
    exp0 = sb[0];
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom_range(0, 255));
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d]: got %b required 1", k, out_valid); else pass_cnt++;
      total_cnt++; if (out_data !== exp0) $display("FAIL bp_hold_data[%0d]: got %h required %h", k, out_data, exp0); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b required 0", k, in_ready); else pass_cnt++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    recv_frame("backpressure", first);
  endtask

  task automatic test_weight_reuse();
    int first;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) tb_w[r][c] = int'($urandom_range(0, 255)) - 128;
    tb_w[0][0] = 16; tb_w[0][1] = 0; tb_w[0][2] = 0;
    for (int i = 0; i < N; i++) tb_x[i] = int'($urandom_range(0, 255)) - 128;
    keep_w = 1'b1;
    send_w(); send_x();
    recv_frame("reuse_f1", first);
    total_cnt++; if (state !== 3'd1) $display("FAIL reuse_state_after: got %0d required 1", state); else pass_cnt++;
    mon_en = 1'b1;
    seen_zero = 1'b0;
    keep_w = 1'b0;
    tb_x[0] = 1; tb_x[1] = 2; tb_x[2] = 3;
    send_x();
    mon_en = 1'b0;
    total_cnt++; if (seen_zero !== 1'b0) $display("FAIL reuse_no_load_w: seen state 0=%b required 0", seen_zero); else pass_cnt++;
    recv_frame("reuse_f2", first);
    total_cnt++; if (state !== 3'd0) $display("FAIL reuse_end_state: got %0d required 0", state); else pass_cnt++;
  endtask

  task automatic test_reset_mid_compute();
    int first;
    keep_w = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) tb_w[r][c] = int'($urandom_range(0, 255)) - 128;
    for (int i = 0; i < N; i++) tb_x[i] = int'($urandom_range(0, 255)) - 128;
    send_w(); send_x();
    repeat (3) @(negedge clk);
    total_cnt++; if (state !== 3'd2) $display("FAIL rst_pre_state: got %0d required 2", state); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (state !== 3'd0) $display("FAIL rst_state: got %0d required 0", state); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b required 0", out_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) tb_w[r][c] = int'($urandom_range(0, 255)) - 128;
    for (int i = 0; i < N; i++) tb_x[i] = int'($urandom_range(0, 255)) - 128;
    send_w(); send_x();
    recv_frame("post_reset", first);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_saturation();
    test_backpressure();
    test_weight_reuse();
    test_reset_mid_compute();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/neuro_matvec_engine.md
Name: neuro_matvec_engine

Overview:
- Parametrised successor to the fixed-size UART-fed matrix multiply core.
- Accepts a byte stream, already deserialised by the UART receiver: an N×N signed weight matrix, then an N-element signed input vector.
- Computes y = W·x with one shared MAC, requantises each result to a signed byte and streams the N result bytes back toward the UART transmitter.
- Adds configurable dimension and width, weight reuse, output saturation and backpressure, none of which the previous core had.

Parameters:
- N, 3, matrix dimension (rows = cols = N), legal range 2..8
- DATA_W, 8, width of weight, input and output elements (signed two's complement)
- ACC_W, 20, accumulator width; must be ≥ 2*DATA_W + clog2(N)
- SHIFT, 4, arithmetic right shift applied to each accumulator before saturation

Ports:
- clk  in  1  single clock, all state rising-edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input byte valid
- in_data  in  DATA_W  input byte
- in_ready  out  1  engine accepts in_data this cycle
- keep_w  in  1  sampled at frame end: 1 = reuse loaded weights for the next frame
- out_valid  out  1  result byte valid
- out_data  out  DATA_W  result byte (signed)
- out_ready  in  1  downstream (TX) accepts out_data
- busy  out  1  high in COMPUTE and SEND
- done  out  1  one-cycle pulse after last result byte accepted
- state  out  3  current FSM state code (debug, drives LEDs)

Behaviour:
- Reset (async assert, sync release):
  - state = LOAD_W; all counters 0; in_ready = 1; out_valid = 0; out_data = 0; busy = 0; done = 0.
  - Weight and vector storage are not cleared.
- State codes: LOAD_W = 0, LOAD_X = 1, COMPUTE = 2, SEND = 3.
- Handshake: a transfer occurs on a cycle where valid & ready are both high.
- in_ready = 1 only in LOAD_W and LOAD_X. out_valid = 1 only in SEND.
- LOAD_W:
  - Each accepted byte is stored row-major at W[r][c]; c increments and wraps at N-1, then r increments.
  - After byte N*N-1 is accepted → LOAD_X.
- LOAD_X:
  - Each accepted byte is stored at x[i].
  - After byte N-1 is accepted → COMPUTE, with row = 0, col = 0, acc = 0.
- COMPUTE:
  - One MAC per cycle: acc += sext(W[row][col]) * sext(x[col]); full-precision signed product.
  - At col = N-1 the completed accumulator is requantised into y[row]; acc clears; row increments.
  - Exactly N*N cycles in COMPUTE, then → SEND with index 0.
- Requantise: t = acc >>> SHIFT (arithmetic). Clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Store.
- SEND:
  - out_data = y[index]; out_valid held high, out_data stable until accepted.
  - Each acceptance increments index.
  - On acceptance of y[N-1]: done pulses next cycle; next state = LOAD_X if keep_w = 1 at that cycle, else LOAD_W.
- Latency: first out_valid appears N*N + 1 cycles after the last x byte handshake.
- in_valid asserted during COMPUTE or SEND is ignored: no storage change, in_ready = 0.
- keep_w = 1 with weights never loaded since reset: reuses whatever storage holds; not an error.
- rst_n low in any state aborts immediately → LOAD_W. A partial frame is discarded; out_valid drops asynchronously.
- Accumulator overflow cannot occur given the ACC_W constraint.

Optional Feature:
- Macro NEURO_RELU_EN.
- Defined: requantised value is additionally clamped to ≥ 0 (ReLU applied after saturation).
- Undefined: signed result passed through unchanged.
- Timing and handshakes are identical either way.

Test Plan:
- Identity (N=3, SHIFT=4): W = identity ×16, x = {16, 32, -48} → out bytes {16, 32, -48} (0x10, 0x20, 0xD0); done one cycle after third accept; first out_valid 10 cycles after last x byte.
- Saturation: all W = 127, x = {127, 127, 127} → acc 48387, >>>4 = 3024 → each output 127. All W = 127, x = {-128, -128, -128} → each output -128.
- Backpressure: hold out_ready = 0 for 20 cycles in SEND → out_valid stays 1, out_data stays y[0]; in_valid pulses in this window are ignored; all 3 bytes arrive in order once out_ready = 1.
- Weight reuse: frame 1 with keep_w = 1, then send only 3 x bytes {1, 2, 3} with W row0 = {16, 0, 0} → y[0] = 1; state goes 3→1, never 0.
- Reset mid-COMPUTE: drop rst_n for 1 cycle → state = 0, out_valid = 0, busy = 0. A fresh full frame then produces correct outputs.
- NEURO_RELU_EN defined: identity case above → outputs {16, 32, 0}.
